// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode constants: opcode field values and immediate format codes.
package legv8_pkg;

    localparam logic [5:0] OP_B     = 6'b000101;
    localparam logic [5:0] OP_BL    = 6'b100101;
    localparam logic [7:0] OP_CBZ   = 8'b10110100;
    localparam logic [7:0] OP_CBNZ  = 8'b10110101;
    localparam logic [7:0] OP_BCOND = 8'b01010100;
    localparam logic [9:0] OP_ADDI  = 10'b1001000100;
    localparam logic [9:0] OP_SUBI  = 10'b1101000100;
    localparam logic [9:0] OP_ANDI  = 10'b1001001000;
    localparam logic [9:0] OP_ORRI  = 10'b1011001000;
    localparam logic [8:0] OP_MOVZ  = 9'b110100101;

    typedef enum logic [2:0] {
        FMT_D  = 3'd0,
        FMT_B  = 3'd1,
        FMT_CB = 3'd2,
        FMT_I  = 3'd3,
        FMT_IW = 3'd4
    } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Classifies a LEGv8 instruction word and produces its extended immediate.
// Purely combinational; no latency, no flow control.
module imm_decode
    import legv8_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit BR_SHIFT = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt
);

    // Everything is built at 64 bits and truncated, so XLEN=32 drops high MOVZ halfwords.
    logic [63:0] imm64;
    fmt_e        fmt_sel;
    logic        unused_bits;

    always_comb begin
        imm64   = {{55{instr[20]}}, instr[20:12]};
        fmt_sel = FMT_D;
        if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
            imm64   = {{38{instr[25]}}, instr[25:0]};
            fmt_sel = FMT_B;
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ ||
                     instr[31:24] == OP_BCOND) begin
            imm64   = {{45{instr[23]}}, instr[23:5]};
            fmt_sel = FMT_CB;
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI ||
                     instr[31:22] == OP_ANDI || instr[31:22] == OP_ORRI) begin
            imm64   = {52'd0, instr[21:10]};
            fmt_sel = FMT_I;
        end else if (instr[31:23] == OP_MOVZ) begin
            imm64   = {48'd0, instr[20:5]} << {instr[22:21], 4'b0000};
            fmt_sel = FMT_IW;
        end

        if (BR_SHIFT && (fmt_sel == FMT_B || fmt_sel == FMT_CB)) begin
            imm64 = imm64 << 2;
        end
    end

    assign imm         = imm64[XLEN-1:0];
    assign fmt         = fmt_sel;
    assign unused_bits = ^{instr[4:0], imm64};

endmodule

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate generator feeding a 2-entry valid/ready skid buffer.
// Latency 1 cycle into an empty buffer; in_ready drops at 2 entries and depends only on registered count.
module imm_extend_pipe
    import legv8_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit BR_SHIFT = 1'b1,
    parameter int TAG_W    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;

    logic [XLEN-1:0]  imm_q [2];
    logic [2:0]       fmt_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    imm_decode #(
        .XLEN     (XLEN),
        .BR_SHIFT (BR_SHIFT)
    ) u_dec (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                imm_q[wr_ptr_q] <= dec_imm;
                fmt_q[wr_ptr_q] <= dec_fmt;
                tag_q[wr_ptr_q] <= in_tag;
            end
        end
    end

    assign out_imm = imm_q[rd_ptr_q];
    assign out_fmt = fmt_q[rd_ptr_q];
    assign out_tag = tag_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Random and directed checks of imm_extend_pipe (XLEN=64/BR_SHIFT=1 and XLEN=32/BR_SHIFT=0)
// against a queue-based reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_tag;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [63:0] out_imm_a, out_tag_a, out_tag_b;
    logic [31:0] out_imm_b;
    logic [2:0]  out_fmt_a, out_fmt_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] imm_a;
        logic [63:0] imm_b;
        logic [2:0]  fmt;
        logic [63:0] tag;
    } exp_t;

    exp_t mq[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(64), .BR_SHIFT(1'b1), .TAG_W(64)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_tag(out_tag_a)
    );

    imm_extend_pipe #(.XLEN(32), .BR_SHIFT(1'b0), .TAG_W(64)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_tag(out_tag_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
        logic [5:0] op6;
        logic [7:0] op8;
        logic [9:0] op10;
        op6  = ins[31:26];
        op8  = ins[31:24];
        op10 = ins[31:22];
        if (op6 == 6'h05 || op6 == 6'h25) return 3'd1;
        if (op8 == 8'hB4 || op8 == 8'hB5 || op8 == 8'h54) return 3'd2;
        if (op10 == 10'h244 || op10 == 10'h344 || op10 == 10'h248 || op10 == 10'h2C8) return 3'd3;
        if (ins[31:23] == 9'h1A5) return 3'd4;
        return 3'd0;
    endfunction

    // Signed field value times a scale, then reduced modulo 2^xlen.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xlen, input bit brs);
        longint v;
        int     hw;
        case (ref_fmt(ins))
            3'd1: begin
                v = longint'(ins[25:0]);
                if (v >= 64'sd33554432) v = v - 64'sd67108864;
                if (brs) v = v * 4;
            end
            3'd2: begin
                v = longint'(ins[23:5]);
                if (v >= 64'sd262144) v = v - 64'sd524288;
                if (brs) v = v * 4;
            end
            3'd3: v = longint'(ins[21:10]);
            3'd4: begin
                v  = longint'(ins[20:5]);
                hw = int'(ins[22:21]);
                for (int k = 0; k < hw; k++) v = v * 65536;
            end
            default: begin
                v = longint'(ins[20:12]);
                if (v >= 64'sd256) v = v - 64'sd512;
            end
        endcase
        if (xlen < 64) v = v & ((64'sd1 <<< xlen) - 64'sd1);
        return 64'(v);
    endfunction

    task automatic check_outputs();
        chk("in_ready_a", {63'd0, in_ready_a}, {63'd0, mq.size() < 2});
        chk("in_ready_b", {63'd0, in_ready_b}, {63'd0, mq.size() < 2});
        chk("out_valid_a", {63'd0, out_valid_a}, {63'd0, mq.size() > 0});
        chk("out_valid_b", {63'd0, out_valid_b}, {63'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk("imm_a", out_imm_a, mq[0].imm_a);
            chk("imm_b", {32'd0, out_imm_b}, mq[0].imm_b);
            chk("fmt_a", {61'd0, out_fmt_a}, {61'd0, mq[0].fmt});
            chk("fmt_b", {61'd0, out_fmt_b}, {61'd0, mq[0].fmt});
            chk("tag_a", out_tag_a, mq[0].tag);
            chk("tag_b", out_tag_b, mq[0].tag);
        end
    endtask

    // Called at posedge+1: drive one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] tg,
                        input logic rdy, input logic fl);
        exp_t e;
        bit   do_push, do_pop;
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = rdy;
        flush     = fl;
        do_push = v && (mq.size() < 2) && !fl;
        do_pop  = (mq.size() > 0) && rdy && !fl;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.imm_a = ref_imm(ins, 64, 1'b1);
                e.imm_b = ref_imm(ins, 32, 1'b0);
                e.fmt   = ref_fmt(ins);
                e.tag   = tg;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic push_known(input logic [31:0] ins, input logic [63:0] ea,
                              input logic [63:0] eb, input logic [2:0] ef);
        step(1'b1, ins, {32'd0, ins}, 1'b1, 1'b0);
        chk("known_valid", {63'd0, out_valid_a}, 64'd1);
        chk("known_imm_a", out_imm_a, ea);
        chk("known_imm_b", {32'd0, out_imm_b}, eb);
        chk("known_fmt", {61'd0, out_fmt_a}, {61'd0, ef});
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r[31:26] = $urandom_range(0, 1) ? 6'h05 : 6'h25;
            1: r[31:24] = ($urandom_range(0, 2) == 0) ? 8'hB4 : (($urandom_range(0, 1) == 0) ? 8'hB5 : 8'h54);
            2: r[31:22] = ($urandom_range(0, 1) == 0) ? 10'h244 : 10'h2C8;
            3: r[31:22] = ($urandom_range(0, 1) == 0) ? 10'h344 : 10'h248;
            4: r[31:23] = 9'h1A5;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] held_imm, held_tag;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_imm", out_imm_a, 64'd0);
        chk("rst_fmt", {61'd0, out_fmt_a}, 64'd0);
        chk("rst_tag", out_tag_a, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready_a}, 64'd1);

        push_known(32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF, 3'd1);
        push_known(32'hB400_0040, 64'd8, 64'd2, 3'd2);
        push_known(32'hF85F_8000, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFF8, 3'd0);
        push_known(32'h913F_FC00, 64'h0000_0000_0000_0FFF, 64'hFFF, 3'd3);
        push_known(32'hD2A0_0020, 64'h1_0000, 64'h1_0000, 3'd4);
        push_known(32'hD2C0_0020, 64'h1_0000_0000, 64'd0, 3'd4);

        // Back-pressure: tags 1,2 accepted, 3 refused, then drained in order.
        step(1'b1, 32'h913F_FC00, 64'd1, 1'b0, 1'b0);
        step(1'b1, 32'hB400_0040, 64'd2, 1'b0, 1'b0);
        chk("bp_full", {63'd0, in_ready_a}, 64'd0);
        held_imm = out_imm_a;
        held_tag = out_tag_a;
        step(1'b1, 32'hD2A0_0020, 64'd3, 1'b0, 1'b0);
        chk("bp_stable_imm", out_imm_a, held_imm);
        chk("bp_stable_tag", out_tag_a, held_tag);
        chk("bp_head1", out_tag_a, 64'd1);
        step(1'b1, 32'hD2A0_0020, 64'd3, 1'b1, 1'b0);
        chk("bp_head2", out_tag_a, 64'd2);
        step(1'b1, 32'hD2A0_0020, 64'd3, 1'b1, 1'b0);
        chk("bp_head3", out_tag_a, 64'd3);
        step(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        chk("bp_empty", {63'd0, out_valid_a}, 64'd0);

        // Flush with two entries, then with one entry and a concurrent push.
        step(1'b1, 32'h17FF_FFFF, 64'd10, 1'b0, 1'b0);
        step(1'b1, 32'h17FF_FFFF, 64'd11, 1'b0, 1'b0);
        step(1'b1, 32'hB400_0040, 64'd12, 1'b0, 1'b1);
        chk("flush2_valid", {63'd0, out_valid_a}, 64'd0);
        step(1'b1, 32'h17FF_FFFF, 64'd13, 1'b0, 1'b0);
        step(1'b1, 32'hB400_0040, 64'd14, 1'b1, 1'b1);
        chk("flush1_valid", {63'd0, out_valid_a}, 64'd0);
        chk("flush1_ready", {63'd0, in_ready_a}, 64'd1);

        // Asynchronous reset between edges with one entry buffered.
        step(1'b1, 32'h913F_FC00, 64'd20, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid_a}, 64'd0);
        chk("arst_imm", out_imm_a, 64'd0);
        mq.delete();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_in_ready", {63'd0, in_ready_a}, 64'd1);
        check_outputs();

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), {$urandom, $urandom},
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
